// File: rtl/ar_seq.sv
// rtl/ar_seq.sv - two-requester address sequencer/arbiter driving AR load/inc and memory strobes
// Optional macro AR_SEQ_WRAP_EN: bursts wrap inside the 8-byte aligned block.
module ar_seq #(
  parameter int BURST_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [15:0]        cpu_addr,
  input  logic [BURST_W-1:0] cpu_len,
  input  logic               cpu_we,
  input  logic               ldr_req,
  input  logic [15:0]        ldr_addr,
  input  logic [BURST_W-1:0] ldr_len,
  input  logic               ldr_we,
  output logic               cpu_gnt,
  output logic               ldr_gnt,
  output logic               cpu_done,
  output logic               ldr_done,
  output logic [15:0]        ar_din,
  output logic               ar_load,
  output logic               ar_inc,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [BURST_W-1:0] beat_idx,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_DONE
  } state_t;

  state_t             state;
  logic [15:0]        cur_addr;
  logic [15:0]        next_addr;
  logic [BURST_W-1:0] len_r;
  logic [BURST_W-1:0] idx_next;
  logic               we_r;
  logic               owner_ldr;
  logic               last_ldr;
  logic               pick_ldr;
  logic               wrap_cur;
  logic               wrap_nxt;
  logic               load_last;
  logic               next_last;

  // Loader wins a tie only when the CPU won the previous grant.
  assign pick_ldr = ldr_req && (!cpu_req || !last_ldr);

`ifdef AR_SEQ_WRAP_EN
  assign wrap_cur = (cur_addr[2:0] == 3'b111);
  assign wrap_nxt = (next_addr[2:0] == 3'b111);
`else
  assign wrap_cur = 1'b0;
  assign wrap_nxt = 1'b0;
`endif

  assign next_addr = wrap_cur ? {cur_addr[15:3], 3'b000} : cur_addr + 16'd1;
  assign idx_next  = beat_idx + BURST_W'(1);
  assign load_last = (len_r == '0);
  assign next_last = (idx_next == len_r);

  // Outputs are registered, so each transition computes the strobes of the cycle it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      len_r     <= '0;
      we_r      <= 1'b0;
      owner_ldr <= 1'b0;
      last_ldr  <= 1'b1;
      cpu_gnt   <= 1'b0;
      ldr_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      ldr_done  <= 1'b0;
      ar_din    <= '0;
      ar_load   <= 1'b0;
      ar_inc    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      beat_idx  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || ldr_req) begin
            state     <= S_LOAD;
            owner_ldr <= pick_ldr;
            cur_addr  <= pick_ldr ? ldr_addr : cpu_addr;
            len_r     <= pick_ldr ? ldr_len : cpu_len;
            we_r      <= pick_ldr ? ldr_we : cpu_we;
            ar_din    <= pick_ldr ? ldr_addr : cpu_addr;
            ar_load   <= 1'b1;
            cpu_gnt   <= !pick_ldr;
            ldr_gnt   <= pick_ldr;
            busy      <= 1'b1;
          end
        end

        S_LOAD: begin
          state    <= S_XFER;
          beat_idx <= '0;
          mem_rd   <= !we_r;
          mem_wr   <= we_r;
          ar_load  <= !load_last && wrap_cur;
          ar_inc   <= !load_last && !wrap_cur;
          ar_din   <= (!load_last && wrap_cur) ? {cur_addr[15:3], 3'b000} : 16'd0;
        end

        S_XFER: begin
          if (beat_idx != len_r) begin
            cur_addr <= next_addr;
            beat_idx <= idx_next;
            ar_load  <= !next_last && wrap_nxt;
            ar_inc   <= !next_last && !wrap_nxt;
            ar_din   <= (!next_last && wrap_nxt) ? {next_addr[15:3], 3'b000} : 16'd0;
          end else begin
            state    <= S_DONE;
            beat_idx <= '0;
            ar_load  <= 1'b0;
            ar_inc   <= 1'b0;
            ar_din   <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            cpu_gnt  <= 1'b0;
            ldr_gnt  <= 1'b0;
            cpu_done <= !owner_ldr;
            ldr_done <= owner_ldr;
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          cpu_done <= 1'b0;
          ldr_done <= 1'b0;
          busy     <= 1'b0;
          last_ldr <= owner_ldr;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ar_seq.sv
// tb/tb_ar_seq.sv - self-checking bench for ar_seq (honours AR_SEQ_WRAP_EN when defined)
module tb_ar_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, ldr_req, cpu_we, ldr_we;
  logic [15:0] cpu_addr, ldr_addr;
  logic [2:0]  cpu_len, ldr_len;
  logic        cpu_gnt, ldr_gnt, cpu_done, ldr_done;
  logic [15:0] ar_din;
  logic        ar_load, ar_inc, mem_rd, mem_wr, busy;
  logic [2:0]  beat_idx;

  ar_seq #(.BURST_W(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_len(cpu_len), .cpu_we(cpu_we),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_len(ldr_len), .ldr_we(ldr_we),
    .cpu_gnt(cpu_gnt), .ldr_gnt(ldr_gnt), .cpu_done(cpu_done), .ldr_done(ldr_done),
    .ar_din(ar_din), .ar_load(ar_load), .ar_inc(ar_inc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .beat_idx(beat_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic gc, gl, dc, dl, ld, inc, rd, wr, bsy, beat;
    logic [15:0] din;
    logic [2:0]  idx;
  } exp_t;

  exp_t        mq[$];
  int          rem = 0;
  bit          last_ldr_m = 1'b1;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  logic [16:0] blog[$];
  logic [16:0] want[$];
  int          glog[$];
  int          n_inc = 0;
  int          n_done = 0;
  logic [15:0] ar_m;
  logic [15:0] xload_din = 16'h0;
  bit          pc = 1'b0, pl = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] baddr(input logic [15:0] a, input int k);
`ifdef AR_SEQ_WRAP_EN
    baddr = {a[15:3], 3'(a[2:0] + 3'(k))};
`else
    baddr = 16'(a + 16'(k));
`endif
  endfunction

  // Expected per-cycle outputs of one transaction: LOAD, len+1 beats, DONE.
  task automatic model_push(input bit ldr, input logic [15:0] a, input int len, input bit we);
    exp_t e;
    logic [15:0] ak, an;
    e = '0; e.gc = !ldr; e.gl = ldr; e.bsy = 1'b1; e.ld = 1'b1; e.din = a;
    mq.push_back(e);
    for (int k = 0; k <= len; k++) begin
      ak = baddr(a, k);
      e = '0; e.gc = !ldr; e.gl = ldr; e.bsy = 1'b1;
      e.rd = !we; e.wr = we; e.beat = 1'b1; e.idx = 3'(k);
      if (k < len) begin
        an = baddr(a, k + 1);
        if (an == 16'(ak + 16'd1)) e.inc = 1'b1;
        else begin e.ld = 1'b1; e.din = an; end
      end
      mq.push_back(e);
    end
    e = '0; e.dc = !ldr; e.dl = ldr; e.bsy = 1'b1;
    mq.push_back(e);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      rem = 0;
      last_ldr_m = 1'b1;
    end else if (rem == 0) begin
      if (cpu_req || ldr_req) begin
        bit w;
        w = ldr_req && !(cpu_req && last_ldr_m);
        if (w) model_push(1'b1, ldr_addr, int'(ldr_len), ldr_we);
        else   model_push(1'b0, cpu_addr, int'(cpu_len), cpu_we);
        last_ldr_m = w;
        rem = 4 + (w ? int'(ldr_len) : int'(cpu_len)) - 1;
      end
    end else begin
      rem = rem - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      e = (mq.size() > 0) ? mq.pop_front() : '0;
      chk("cpu_gnt", cpu_gnt, e.gc);
      chk("ldr_gnt", ldr_gnt, e.gl);
      chk("cpu_done", cpu_done, e.dc);
      chk("ldr_done", ldr_done, e.dl);
      chk("ar_load", ar_load, e.ld);
      chk("ar_inc", ar_inc, e.inc);
      chk("mem_rd", mem_rd, e.rd);
      chk("mem_wr", mem_wr, e.wr);
      chk("busy", busy, e.bsy);
      if (e.ld) chk("ar_din", ar_din, e.din);
      if (e.beat) chk("beat_idx", beat_idx, e.idx);
    end
  end

  // Reference AR register and observation logs used by the directed checks.
  always @(posedge clk) begin
    if (ar_load) ar_m <= ar_din;
    else if (ar_inc) ar_m <= ar_m + 16'd1;
  end

  always @(negedge clk) begin
    if (mem_rd || mem_wr) blog.push_back({mem_wr, ar_m});
    if ((mem_rd || mem_wr) && ar_load) xload_din = ar_din;
    if (ar_inc) n_inc++;
    if (cpu_done || ldr_done) n_done++;
    if (cpu_gnt && !pc) glog.push_back(0);
    if (ldr_gnt && !pl) glog.push_back(1);
    pc = cpu_gnt;
    pl = ldr_gnt;
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, 32'(n < 40), 32'd1);
  endtask

  task automatic chk_beats(input string nm);
    chk({nm, "_nbeats"}, blog.size(), want.size());
    for (int i = 0; i < want.size() && i < blog.size(); i++)
      chk({nm, "_beat"}, blog[i], want[i]);
  endtask

  task automatic clear_logs();
    blog.delete(); want.delete(); glog.delete();
    n_inc = 0; n_done = 0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    cpu_req = 1'b0; ldr_req = 1'b0; cpu_we = 1'b0; ldr_we = 1'b0;
    cpu_addr = '0; ldr_addr = '0; cpu_len = '0; ldr_len = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnts", {cpu_gnt, ldr_gnt}, 2'b00);
    chk("rst_strobes", {ar_load, ar_inc, mem_rd, mem_wr}, 4'b0000);

    // CPU read burst, 4 beats from 0100
    clear_logs();
    cpu_addr = 16'h0100; cpu_len = 3'd3; cpu_we = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 1;
    chk("t1_load", ar_load, 1'b1);
    chk("t1_load_din", ar_din, 16'h0100);
    while (!cpu_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t1_done_cycle", cyc, 6);
    chk("t1_ar_inc_count", n_inc, 3);
    want.push_back(17'h00100); want.push_back(17'h00101);
    want.push_back(17'h00102); want.push_back(17'h00103);
    chk_beats("t1");
    wait_idle("t1");

    // Both requesting from reset: grants CPU, LDR, CPU
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    cpu_addr = 16'h0200; cpu_len = 3'd0; cpu_we = 1'b0;
    ldr_addr = 16'h0300; ldr_len = 3'd0; ldr_we = 1'b1;
    cpu_req = 1'b1; ldr_req = 1'b1;
    cyc = 0;
    while (glog.size() < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    chk("t2_grant_timeout", 32'(glog.size() >= 3), 32'd1);
    if (glog.size() >= 3) begin
      chk("t2_grant0", glog[0], 0);
      chk("t2_grant1", glog[1], 1);
      chk("t2_grant2", glog[2], 0);
    end
    wait_idle("t2");

    // Loader write burst across the rollover / wrap boundary
    clear_logs();
`ifdef AR_SEQ_WRAP_EN
    ldr_addr = 16'h0106;
    want.push_back(17'h10106); want.push_back(17'h10107);
    want.push_back(17'h10100); want.push_back(17'h10101);
`else
    ldr_addr = 16'hFFFE;
    want.push_back(17'h1FFFE); want.push_back(17'h1FFFF);
    want.push_back(17'h10000); want.push_back(17'h10001);
`endif
    ldr_len = 3'd3; ldr_we = 1'b1; ldr_req = 1'b1;
    @(negedge clk);
    ldr_req = 1'b0;
    wait_idle("t3");
    chk_beats("t3");
    chk("t3_done_count", n_done, 1);
`ifdef AR_SEQ_WRAP_EN
    chk("t3_wrap_din", xload_din, 16'h0100);
    chk("t3_ar_inc_count", n_inc, 2);
`else
    chk("t3_ar_inc_count", n_inc, 3);
`endif

    // Reset in beat 2 of a len-7 burst, then a fresh request
    clear_logs();
    cpu_addr = 16'h2000; cpu_len = 3'd7; cpu_we = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 0;
    while (!(mem_rd && beat_idx == 3'd2) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_beat2_timeout", 32'(cyc < 30), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_outs_zero",
        {cpu_gnt, ldr_gnt, cpu_done, ldr_done, ar_load, ar_inc, mem_rd, mem_wr, busy}, 9'd0);
    chk("t4_din_zero", ar_din, 16'h0000);
    repeat (5) @(negedge clk);
    chk("t4_no_done", n_done, 0);
    blog.delete();
    cpu_addr = 16'h0030; cpu_len = 3'd1; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    wait_idle("t4");
    want.push_back(17'h00030); want.push_back(17'h00031);
    chk_beats("t4");
    chk("t4_done_after", n_done, 1);

    // Request changes during XFER do not disturb the current burst
    clear_logs();
    cpu_addr = 16'h4000; cpu_len = 3'd2; cpu_we = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = 16'h9999;
    ldr_addr = 16'h5000; ldr_len = 3'd0; ldr_we = 1'b1; ldr_req = 1'b1;
    cyc = 0;
    while (!ldr_gnt && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    ldr_req = 1'b0;
    chk("t5_ldr_gnt_timeout", 32'(cyc < 30), 32'd1);
    chk("t5_cpu_done_first", n_done, 1);
    wait_idle("t5");
    want.push_back(17'h04000); want.push_back(17'h04001);
    want.push_back(17'h04002); want.push_back(17'h15000);
    chk_beats("t5");
    chk("t5_ngrants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t5_grant0", glog[0], 0);
      chk("t5_grant1", glog[1], 1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
